alu_muldiv_mips: RTL and testbench

//   Parametrised MIPS execute-stage ALU: single-cycle logic/arith/shift ops plus iterative

---
 rtl/alu_mips_pkg.sv | 30 +++
 rtl/muldiv_iter.sv | 131 +++++++++++++
 rtl/alu_muldiv_mips.sv | 56 +++++
 tb/tb_alu_muldiv_mips.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_mips_pkg.sv
// Shared definitions for the MIPS execute-stage ALU: control codes and the mul/div sequencer states.
package alu_mips_pkg;

  localparam logic [3:0] ALU_AND   = 4'd0;
  localparam logic [3:0] ALU_OR    = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SRL   = 4'd3;
  localparam logic [3:0] ALU_ADD   = 4'd4;
  localparam logic [3:0] ALU_SUB   = 4'd6;
  localparam logic [3:0] ALU_SLT   = 4'd7;
  localparam logic [3:0] ALU_MULT  = 4'd8;
  localparam logic [3:0] ALU_MULTU = 4'd9;
  localparam logic [3:0] ALU_DIV   = 4'd10;
  localparam logic [3:0] ALU_DIVU  = 4'd11;
  localparam logic [3:0] ALU_NOR   = 4'd12;
  localparam logic [3:0] ALU_MFHI  = 4'd13;
  localparam logic [3:0] ALU_MFLO  = 4'd14;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  function automatic logic is_seq_op(input logic [3:0] code);
    return (code == ALU_MULT) || (code == ALU_MULTU) || (code == ALU_DIV) || (code == ALU_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative radix-2 multiply / restoring divide on operand magnitudes, with sign fix-up into HI/LO.
module muldiv_iter
  import alu_mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       control,
  input  logic             start,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int SW = $clog2(WIDTH);

  state_t             state, state_next;
  logic [SW-1:0]      cnt;
  logic [2*WIDTH:0]   acc;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   dividend_raw;
  logic               neg_main, neg_rem, div_zero, op_mul;

  logic               accept, op_signed;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     r_shift, trial;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign accept    = start && (state == S_IDLE) && is_seq_op(control);
  assign op_signed = (control == ALU_MULT) || (control == ALU_DIV);
  assign busy      = (state != S_IDLE);

  always_comb begin
    a_mag    = (op_signed && a[WIDTH-1]) ? -a : a;
    b_mag    = (op_signed && b[WIDTH-1]) ? -b : b;
    mul_sum  = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, mcand} : '0);
    r_shift  = {rem, quo[WIDTH-1]};
    trial    = r_shift - {1'b0, mcand};
    prod_fix = neg_main ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
    quo_fix  = neg_main ? -quo : quo;
    rem_fix  = neg_rem ? -rem : rem;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept) state_next = (control == ALU_MULT || control == ALU_MULTU) ? S_MUL : S_DIV;
      S_MUL,
      S_DIV:  if (cnt == '0) state_next = S_FIX;
      S_FIX:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Operands are captured as magnitudes at acceptance; signs are reapplied only in FIX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      acc          <= '0;
      mcand        <= '0;
      rem          <= '0;
      quo          <= '0;
      dividend_raw <= '0;
      neg_main     <= 1'b0;
      neg_rem      <= 1'b0;
      div_zero     <= 1'b0;
      op_mul       <= 1'b0;
      hi           <= '0;
      lo           <= '0;
      done         <= 1'b0;
    end else begin
      done <= (state == S_FIX);
      case (state)
        S_IDLE: if (accept) begin
          op_mul       <= (control == ALU_MULT) || (control == ALU_MULTU);
          cnt          <= SW'(WIDTH - 1);
          acc          <= {{(WIDTH+1){1'b0}}, b_mag};
          mcand        <= ((control == ALU_MULT) || (control == ALU_MULTU)) ? a_mag : b_mag;
          quo          <= a_mag;
          rem          <= '0;
          dividend_raw <= a;
          neg_main     <= op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_rem      <= op_signed && a[WIDTH-1];
          div_zero     <= (b == '0);
        end
        S_MUL: begin
          acc <= {1'b0, mul_sum, acc[WIDTH-1:1]};
          cnt <= cnt - 1'b1;
        end
        S_DIV: begin
          cnt <= cnt - 1'b1;
          if (!div_zero) begin
            if (!trial[WIDTH]) begin
              rem <= trial[WIDTH-1:0];
              quo <= {quo[WIDTH-2:0], 1'b1};
            end else begin
              rem <= r_shift[WIDTH-1:0];
              quo <= {quo[WIDTH-2:0], 1'b0};
            end
          end
        end
        S_FIX: begin
          if (op_mul) begin
            {hi, lo} <= prod_fix;
          end else if (div_zero) begin
            hi <= dividend_raw;
            lo <= '1;
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_muldiv_mips.sv
// MIPS EX-stage ALU: combinational op mux and zero flag around the iterative HI/LO mul/div unit.
module alu_muldiv_mips
  import alu_mips_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SW-1:0]    shamt,
  input  logic [3:0]       control,
  input  logic             start,
  output logic [WIDTH-1:0] outalu,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  logic [WIDTH-1:0] hi, lo;

  muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a),
    .b       (b),
    .control (control),
    .start   (start),
    .hi      (hi),
    .lo      (lo),
    .busy    (busy),
    .done    (done)
  );

  // MFHI/MFLO expose the architectural registers as-is, so reads during busy see the previous result.
  always_comb begin
    outalu = '0;
    case (control)
      ALU_AND:  outalu = a & b;
      ALU_OR:   outalu = a | b;
      ALU_SLL:  outalu = a << shamt;
      ALU_SRL:  outalu = a >> shamt;
      ALU_ADD:  outalu = a + b;
      ALU_SUB:  outalu = a - b;
      ALU_SLT:  outalu = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_NOR:  outalu = ~(a | b);
      ALU_MFHI: outalu = hi;
      ALU_MFLO: outalu = lo;
      default:  outalu = '0;
    endcase
  end

  assign zero = (outalu == '0);

endmodule

// File: tb/tb_alu_muldiv_mips.sv
// Self-checking bench: arithmetic reference model of HI/LO and timing, plus hand-computed vectors.
module tb_alu_muldiv_mips;

  localparam int WIDTH = 32;
  localparam int SW    = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [WIDTH-1:0]  a, b;
  logic [SW-1:0]     shamt;
  logic [3:0]        control;
  logic              start;
  logic [WIDTH-1:0]  outalu;
  logic              zero, busy, done;

  int compares = 0;
  int errors   = 0;

  logic [WIDTH-1:0] model_hi, model_lo;
  logic [WIDTH-1:0] pend_hi, pend_lo;
  int               model_cnt;
  logic             model_done;

  alu_muldiv_mips #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a),
    .b       (b),
    .shamt   (shamt),
    .control (control),
    .start   (start),
    .outalu  (outalu),
    .zero    (zero),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Reference result of a mul/div computed with wide plain arithmetic.
  task automatic modelOp(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] rh, output logic [31:0] rl);
    longint      sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    rh = '0;
    rl = '0;
    case (op)
      4'd8:  begin p = 64'(sx * sy); rh = p[63:32]; rl = p[31:0]; end
      4'd9:  begin p = 64'(x) * 64'(y); rh = p[63:32]; rl = p[31:0]; end
      4'd10: if (y == 0) begin rh = x; rl = '1; end
             else begin q = sx / sy; r = sx % sy; rh = 32'(r); rl = 32'(q); end
      4'd11: if (y == 0) begin rh = x; rl = '1; end
             else begin rh = x % y; rl = x / y; end
      default: ;
    endcase
  endtask

  function automatic logic [31:0] modelComb(input logic [3:0] op, input logic [31:0] x,
                                            input logic [31:0] y, input logic [4:0] s);
    case (op)
      4'd0:  return x & y;
      4'd1:  return x | y;
      4'd2:  return x << s;
      4'd3:  return x >> s;
      4'd4:  return x + y;
      4'd6:  return x - y;
      4'd7:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd12: return ~(x | y);
      4'd13: return model_hi;
      4'd14: return model_lo;
      default: return 32'd0;
    endcase
  endfunction

  // Model timing: a launched op becomes visible WIDTH+1 edges after its accepting edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_hi   = '0;
      model_lo   = '0;
      model_cnt  = 0;
      model_done = 1'b0;
    end else if (model_cnt > 0) begin
      model_cnt  = model_cnt - 1;
      model_done = (model_cnt == 0);
      if (model_cnt == 0) begin
        model_hi = pend_hi;
        model_lo = pend_lo;
      end
    end else begin
      model_done = 1'b0;
      if (start && control >= 4'd8 && control <= 4'd11) begin
        modelOp(control, a, b, pend_hi, pend_lo);
        model_cnt = WIDTH + 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compares++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("outalu", outalu, modelComb(control, a, b, shamt));
    checkOutput("zero", 32'(zero), 32'(modelComb(control, a, b, shamt) == 0));
    checkOutput("busy", 32'(busy), 32'(model_cnt > 0));
    checkOutput("done", 32'(done), 32'(model_done));
  end

  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                               input logic [4:0] s, input logic st);
    @(posedge clk);
    #1;
    control = op;
    a       = x;
    b       = y;
    shamt   = s;
    start   = st;
  endtask

  task automatic runOp(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                       output int cycles);
    applyStimulus(op, x, y, 5'd0, 1'b1);
    @(posedge clk);
    #1;
    start  = 1'b0;
    cycles = 0;
    while (!done && cycles < 100) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic checkHiLo(input string name, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    control = 4'd13;
    #1;
    checkOutput({name, "_hi"}, outalu, exp_hi);
    control = 4'd14;
    #1;
    checkOutput({name, "_lo"}, outalu, exp_lo);
  endtask

  logic [3:0]  vec_op [10] = '{4'd0, 4'd12, 4'd7, 4'd1, 4'd4, 4'd6, 4'd2, 4'd3, 4'd5, 4'd9};
  logic [31:0] vec_a  [10] = '{32'h0000000F, 32'h0000000F, 32'hFFFFFFFF, 32'h0000000F, 32'hFFFFFFFF,
                               32'd5, 32'h0000000F, 32'h80000000, 32'h12345678, 32'h12345678};
  logic [31:0] vec_b  [10] = '{32'h000000F0, 32'h000000F0, 32'd1, 32'h000000F0, 32'd1,
                               32'd7, 32'd0, 32'd0, 32'h1, 32'h1};
  logic [4:0]  vec_s  [10] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd4, 5'd31, 5'd0, 5'd0};
  logic [31:0] vec_e  [10] = '{32'h0, 32'hFFFFFF00, 32'd1, 32'hFF, 32'h0,
                               32'hFFFFFFFE, 32'hF0, 32'h1, 32'h0, 32'h0};

  initial begin
    int cyc;
    rst_n   = 1'b0;
    a       = '0;
    b       = '0;
    shamt   = '0;
    control = 4'd13;
    start   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] reset state");
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_mfhi", outalu, 32'd0);
    checkOutput("rst_zero", 32'(zero), 32'd1);

    $display("[TB] combinational vectors");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vec_op[i], vec_a[i], vec_b[i], vec_s[i], 1'b0);
      #1;
      checkOutput("comb", outalu, vec_e[i]);
      checkOutput("comb_zero", 32'(zero), 32'(vec_e[i] == 0));
    end

    $display("[TB] multiply");
    runOp(4'd8, 32'hFFFFFFFD, 32'd7, cyc);
    checkOutput("mult_latency", 32'(cyc), 32'd33);
    checkHiLo("mult", 32'hFFFFFFFF, 32'hFFFFFFEB);
    runOp(4'd9, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc);
    checkHiLo("multu", 32'hFFFFFFFE, 32'h00000001);
    runOp(4'd8, 32'h80000000, 32'h80000000, cyc);
    checkHiLo("mult_minmin", 32'h40000000, 32'h00000000);

    $display("[TB] divide");
    runOp(4'd10, 32'hFFFFFFF9, 32'd2, cyc);
    checkOutput("div_latency", 32'(cyc), 32'd33);
    checkHiLo("div", 32'hFFFFFFFF, 32'hFFFFFFFD);
    runOp(4'd11, 32'd100, 32'd7, cyc);
    checkHiLo("divu", 32'd2, 32'd14);
    runOp(4'd10, 32'd7, 32'hFFFFFFFE, cyc);
    checkHiLo("div_negdiv", 32'd1, 32'hFFFFFFFD);
    runOp(4'd11, 32'd5, 32'd0, cyc);
    checkOutput("divz_latency", 32'(cyc), 32'd33);
    checkHiLo("divu_zero", 32'd5, 32'hFFFFFFFF);
    runOp(4'd10, 32'h80000000, 32'hFFFFFFFF, cyc);
    checkHiLo("div_ovf", 32'd0, 32'h80000000);

    $display("[TB] start while busy");
    applyStimulus(4'd11, 32'd100, 32'd7, 5'd0, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(4'd9, 32'd3 + 32'(i), 32'd3, 5'd0, 1'b1);
    applyStimulus(4'd14, 32'd0, 32'd0, 5'd0, 1'b0);
    #1;
    checkOutput("mflo_busy", outalu, 32'h80000000);
    cyc = 0;
    while (!done && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checkOutput("busy_done_seen", 32'(done), 32'd1);
    checkHiLo("divu_held", 32'd2, 32'd14);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("no_queue_busy", 32'(busy), 32'd0);

    $display("[TB] reset mid-divide");
    applyStimulus(4'd10, 32'hFFFFFFF9, 32'd2, 5'd0, 1'b1);
    applyStimulus(4'd10, 32'hFFFFFFF9, 32'd2, 5'd0, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkHiLo("abort", 32'd0, 32'd0);
    checkOutput("abort_zero", 32'(zero), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
    $finish;
  end

endmodule
